// File: rtl/nanosoc_uart_pkg.sv
// rtl/nanosoc_uart_pkg.sv - shared UART receiver constants, FSM state encodings and parity helper
package nanosoc_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic [7:0] ASCII_EOT = 8'h04;

  // Receiver FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Even-parity bit that makes the total count of ones in data+parity even
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nanosoc_axi_stream_fifo_8.sv
// rtl/nanosoc_axi_stream_fifo_8.sv - synchronous byte FIFO with AXI-stream style read side
module nanosoc_axi_stream_fifo_8 #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] in_tdata,
  input  logic       in_tvalid,
  output logic       in_tready,
  output logic [7:0] out_tdata,
  output logic       out_tvalid,
  input  logic       out_tready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Extra pointer MSB separates the full and empty cases when the indices match
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_tvalid = !empty;
  assign out_tdata  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign pop        = out_tvalid && out_tready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign in_tready  = !full || out_tready;
  assign push       = in_tvalid && in_tready;

  // Pointer update on push/pop
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since empty masks the read data
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_tdata;
  end

endmodule

// File: rtl/nanosoc_uart_rx_to_axi_stream_8.sv
// rtl/nanosoc_uart_rx_to_axi_stream_8.sv - UART 8N1 receiver to AXI-stream bytes; NANOSOC_UART_RX_PARITY_EN selects 8E1
module nanosoc_uart_rx_to_axi_stream_8
  import nanosoc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       uart_rxd,
  output logic       rxd8_valid,
  input  logic       rxd8_ready,
  output logic [7:0] rxd8_data,
  output logic       rx_busy,
  output logic       framing_error,
  output logic       overrun,
  output logic       parity_error
);

  localparam logic [15:0] BAUD_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BAUD_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic        rxd_meta;
  logic        rxd_sync;
  logic        rxd_prev;
  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        push_req;
  logic [7:0]  push_data;
  logic        fifo_in_tready;
  logic        baud_tick;

  assign baud_tick = (baud_cnt == 16'd0);
  assign rx_busy   = (state != ST_IDLE);

  // Two-flop synchroniser plus a history flop for falling-edge detection
  always_ff @(posedge aclk) begin
    if (areset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

`ifdef NANOSOC_UART_RX_PARITY_EN
  logic parity_bad;
  logic parity_error_r;
  assign parity_error = parity_error_r;
`else
  assign parity_error = 1'b0;
`endif

  // Frame FSM: start qualification, mid-bit sampling, stop check and push request
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      baud_cnt      <= 16'd0;
      bit_cnt       <= 3'd0;
      shift_reg     <= 8'h00;
      push_req      <= 1'b0;
      push_data     <= 8'h00;
      framing_error <= 1'b0;
`ifdef NANOSOC_UART_RX_PARITY_EN
      parity_bad     <= 1'b0;
      parity_error_r <= 1'b0;
`endif
    end else begin
      push_req      <= 1'b0;
      framing_error <= 1'b0;
`ifdef NANOSOC_UART_RX_PARITY_EN
      parity_error_r <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            state    <= ST_START;
            baud_cnt <= BAUD_HALF;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            if (!rxd_sync) begin
              state    <= ST_DATA;
              baud_cnt <= BAUD_FULL;
              bit_cnt  <= 3'd0;
`ifdef NANOSOC_UART_RX_PARITY_EN
              parity_bad <= 1'b0;
`endif
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            baud_cnt  <= BAUD_FULL;
            if (bit_cnt == LAST_BIT) begin
`ifdef NANOSOC_UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef NANOSOC_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            if (rxd_sync != even_parity(shift_reg)) begin
              parity_error_r <= 1'b1;
              parity_bad     <= 1'b1;
            end
            state    <= ST_STOP;
            baud_cnt <= BAUD_FULL;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            if (rxd_sync) begin
`ifdef NANOSOC_UART_RX_PARITY_EN
              push_req <= !parity_bad;
`else
              push_req <= 1'b1;
`endif
              push_data <= shift_reg;
              state     <= ST_IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= ST_WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxd_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Overrun pulse when the FIFO cannot take the pushed byte
  always_ff @(posedge aclk) begin
    if (areset) overrun <= 1'b0;
    else        overrun <= push_req && !fifo_in_tready;
  end

  nanosoc_axi_stream_fifo_8 #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .aclk       (aclk),
    .areset     (areset),
    .in_tdata   (push_data),
    .in_tvalid  (push_req),
    .in_tready  (fifo_in_tready),
    .out_tdata  (rxd8_data),
    .out_tvalid (rxd8_valid),
    .out_tready (rxd8_ready)
  );

endmodule

// File: tb/tb_nanosoc_uart_rx_to_axi_stream_8.sv
// tb/tb_nanosoc_uart_rx_to_axi_stream_8.sv - self-checking bench for the UART RX to AXI-stream bridge
module tb_nanosoc_uart_rx_to_axi_stream_8;
  import nanosoc_uart_pkg::*;

  localparam int CPB = 16;
`ifdef NANOSOC_UART_RX_PARITY_EN
  localparam int LAT = 172;
`else
  localparam int LAT = 156;
`endif

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rxd8_ready = 1'b0;
  logic       rxd8_valid;
  logic [7:0] rxd8_data;
  logic       rx_busy;
  logic       framing_error;
  logic       overrun;
  logic       parity_error;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int framing_cnt = 0;
  int overrun_cnt = 0;
  int parity_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 aclk = ~aclk;

  nanosoc_uart_rx_to_axi_stream_8 #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .uart_rxd      (uart_rxd),
    .rxd8_valid    (rxd8_valid),
    .rxd8_ready    (rxd8_ready),
    .rxd8_data     (rxd8_data),
    .rx_busy       (rx_busy),
    .framing_error (framing_error),
    .overrun       (overrun),
    .parity_error  (parity_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge aclk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge aclk);
    end
`ifdef NANOSOC_UART_RX_PARITY_EN
    uart_rxd = par_bit;
    repeat (CPB) @(negedge aclk);
`else
    if (par_bit !== (^b)) $display("note: parity bit ignored in 8N1 build");
`endif
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge aclk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bits(b, ^b, stop_bit);
  endtask

  // Scoreboard: every transfer must match the next expected byte; held outputs must stay stable
  initial begin
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_reset = 1'b1;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge aclk);
      #1;
      if (!areset) begin
        if (framing_error) framing_cnt++;
        if (overrun)       overrun_cnt++;
        if (parity_error)  parity_cnt++;
        if (prev_valid && !prev_ready && !prev_reset) begin
          check("hold_valid", rxd8_valid, 1);
          check("hold_data", rxd8_data, prev_data);
        end
        if (rxd8_valid && rxd8_ready) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_byte: got %0h expected no transfer", rxd8_data);
          end else begin
            check("xfer_data", rxd8_data, exp_q.pop_front());
          end
        end
      end
      prev_valid = rxd8_valid;
      prev_ready = rxd8_ready;
      prev_data  = rxd8_data;
      prev_reset = areset;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset values
    repeat (4) @(negedge aclk);
    check("rst_valid", rxd8_valid, 0);
    check("rst_data", rxd8_data, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_framing", framing_error, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity", parity_error, 0);
    areset = 1'b0;
    repeat (4) @(negedge aclk);

    // single byte, latency from start-bit drive to valid
    rxd8_ready = 1'b1;
    exp_q.push_back(8'h41);
    fork
      send_frame(8'h41, 1'b1);
      begin
        n = 0;
        while (!rxd8_valid && n < 400) begin
          @(posedge aclk);
          #1;
          n++;
        end
        check("latency_0x41", n, LAT);
        check("data_0x41", rxd8_data, 8'h41);
      end
    join
    repeat (20) @(negedge aclk);

    // back-pressure: four held, fifth dropped with overrun
    rxd8_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    repeat (5) @(negedge aclk);
    check("overrun_count", overrun_cnt, 1);
    check("held_valid", rxd8_valid, 1);
    check("held_head", rxd8_data, 8'h01);
    rxd8_ready = 1'b1;
    repeat (4) @(negedge aclk);
    #2;
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid_low", rxd8_valid, 0);
    @(negedge aclk);

    // full FIFO with a pop in the push cycle: no overrun
    rxd8_ready = 1'b0;
    for (int v = 8'h21; v <= 8'h24; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    exp_q.push_back(8'h25);
    fork
      send_frame(8'h25, 1'b1);
      begin
        repeat (LAT - 1) @(negedge aclk);
        rxd8_ready = 1'b1;
        @(negedge aclk);
        rxd8_ready = 1'b0;
      end
    join
    repeat (5) @(negedge aclk);
    check("no_overrun_on_pop", overrun_cnt, 1);
    rxd8_ready = 1'b1;
    repeat (5) @(negedge aclk);
    #2;
    check("simul_drain_empty", exp_q.size(), 0);
    @(negedge aclk);

    // framing error, long break, then a clean byte
    send_frame(8'h55, 1'b0);
    uart_rxd = 1'b0;
    repeat (40 * CPB) @(negedge aclk);
    check("framing_count", framing_cnt, 1);
    check("break_busy", rx_busy, 1);
    uart_rxd = 1'b1;
    repeat (32) @(negedge aclk);
    check("break_released", rx_busy, 0);
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    repeat (10) @(negedge aclk);
    check("after_break_empty", exp_q.size(), 0);
    check("framing_once", framing_cnt, 1);

    // 8-cycle glitch at idle
    uart_rxd = 1'b0;
    repeat (8) @(negedge aclk);
    uart_rxd = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("glitch_busy", rx_busy, 1);
    @(posedge aclk);
    #1;
    check("glitch_idle", rx_busy, 0);
    @(negedge aclk);
    repeat (40) @(negedge aclk);
    check("glitch_no_flag", framing_cnt, 1);

    // reset mid data bit 4 flushes the FIFO and aborts the frame
    rxd8_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    repeat (4) @(negedge aclk);
    check("pre_reset_valid", rxd8_valid, 1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (85) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        check("midrst_busy", rx_busy, 0);
        check("midrst_valid", rxd8_valid, 0);
        check("midrst_data", rxd8_data, 0);
        areset = 1'b0;
      end
    join
    rxd8_ready = 1'b1;
    repeat (20) @(negedge aclk);
    check("post_reset_valid", rxd8_valid, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (10) @(negedge aclk);
    check("post_reset_byte", exp_q.size(), 0);

    // boundary data values including EOT pass-through
    exp_q.push_back(ASCII_EOT);
    send_frame(ASCII_EOT, 1'b1);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    repeat (10) @(negedge aclk);
    check("boundary_empty", exp_q.size(), 0);

`ifdef NANOSOC_UART_RX_PARITY_EN
    send_bits(8'h03, 1'b1, 1'b1);
    repeat (10) @(negedge aclk);
    check("parity_error_count", parity_cnt, 1);
    exp_q.push_back(8'h03);
    send_bits(8'h03, 1'b0, 1'b1);
    repeat (10) @(negedge aclk);
    check("parity_good_byte", exp_q.size(), 0);
`else
    check("parity_never", parity_cnt, 0);
`endif
    check("overrun_total", overrun_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
